// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the memory-access / write-back boundary.
package mem_wb_stage_pkg;

   localparam int unsigned LUI_IMM_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HALTED
   } memstate_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB latch outputs handed to the write-back stage and the datapath halt output.
interface mem_wb_stage_if #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned REG_W  = 5
);
   logic              wbWEN;
   logic [REG_W-1:0]  wbwsel;
   logic [WORD_W-1:0] wbwdat;
   logic [WORD_W-1:0] wbinstr;
   logic              wbHALT;

   modport master (output wbWEN, wbwsel, wbwdat, wbinstr, wbHALT);
   modport slave  (input  wbWEN, wbwsel, wbwdat, wbinstr, wbHALT);
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage: dcache handshake, upstream stall, write-back select and MEM/WB register.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              memcuDRE,
   input  logic              memcuDWE,
   input  logic              memcuHALT,
   input  logic              memMemToReg,
   input  logic              memWEN,
   input  logic [REG_W-1:0]  memwsel,
   input  logic [WORD_W-1:0] memOutput_Port,
   input  logic [WORD_W-1:0] memrdat2,
   input  logic [WORD_W-1:0] meminstr,
   input  logic              memLUIflag,
   input  logic              wbFlush,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dload,
   output logic              dREN,
   output logic              dWEN,
   output logic [WORD_W-1:0] daddr,
   output logic [WORD_W-1:0] dstore,
   output logic              memStall,
   output logic [CNT_W-1:0]  stallCount,
   mem_wb_stage_if.master    wb
);

   memstate_t         state;
   logic              active;
   logic              halt_take;
   logic [WORD_W-1:0] wdat;

   // nRST gates the requests combinationally so an abandoned access drops at once.
   assign active    = nRST && (state != HALTED);
   assign dWEN      = active & memcuDWE;
   assign dREN      = active & memcuDRE & ~memcuDWE;
   assign memStall  = (dREN | dWEN) & ~dhit;
   assign halt_take = active & memcuHALT & ~memStall & ~wbFlush;
   assign daddr     = memOutput_Port;
   assign dstore    = memrdat2;

   always_comb begin
      wdat = memOutput_Port;
      if (memMemToReg)
         wdat = dload;
      else if (memLUIflag)
         wdat = {meminstr[LUI_IMM_W-1:0], {(WORD_W-LUI_IMM_W){1'b0}}};
   end

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         stallCount <= '0;
         wb.wbWEN   <= 1'b0;
         wb.wbwsel  <= '0;
         wb.wbwdat  <= '0;
         wb.wbinstr <= '0;
         wb.wbHALT  <= 1'b0;
      end else begin
         case (state)
            HALTED: begin
               wb.wbWEN <= 1'b0;
            end
            default: begin
               if (memStall) begin
                  state    <= WAIT;
                  wb.wbWEN <= 1'b0;
                  if (stallCount != '1)
                     stallCount <= stallCount + CNT_W'(1);
               end else begin
                  state <= halt_take ? HALTED : IDLE;
                  if (wbFlush) begin
                     wb.wbWEN   <= 1'b0;
                     wb.wbwsel  <= '0;
                     wb.wbwdat  <= '0;
                     wb.wbinstr <= '0;
                  end else begin
                     wb.wbWEN   <= memWEN;
                     wb.wbwsel  <= memwsel;
                     wb.wbwdat  <= wdat;
                     wb.wbinstr <= meminstr;
                  end
                  if (halt_take)
                     wb.wbHALT <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a transaction-level reference model.
module tb_mem_wb_stage;

   localparam int unsigned CNT_W = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        memcuDRE = 1'b0, memcuDWE = 1'b0, memcuHALT = 1'b0;
   logic        memMemToReg = 1'b0, memWEN = 1'b0, memLUIflag = 1'b0;
   logic        wbFlush = 1'b0, dhit = 1'b0;
   logic [4:0]  memwsel = '0;
   logic [31:0] memOutput_Port = '0, memrdat2 = '0, meminstr = '0, dload = '0;
   logic        dREN, dWEN, memStall;
   logic [31:0] daddr, dstore;
   logic [CNT_W-1:0] stallCount;

   mem_wb_stage_if #(.WORD_W(32), .REG_W(5)) wb_if ();

   mem_wb_stage #(.WORD_W(32), .REG_W(5), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST),
      .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
      .memMemToReg(memMemToReg), .memWEN(memWEN), .memwsel(memwsel),
      .memOutput_Port(memOutput_Port), .memrdat2(memrdat2), .meminstr(meminstr),
      .memLUIflag(memLUIflag), .wbFlush(wbFlush), .dhit(dhit), .dload(dload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .memStall(memStall), .stallCount(stallCount), .wb(wb_if.master)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: only "halted" matters for outputs; wait-state is implied by inputs.
   logic        m_halt, m_wen, m_whalt, prev_stall;
   logic [4:0]  m_wsel;
   logic [31:0] m_wdat, m_instr;
   int          m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_halt = 1'b0; m_wen = 1'b0; m_whalt = 1'b0; prev_stall = 1'b0;
      m_wsel = '0; m_wdat = '0; m_instr = '0; m_cnt = 0;
   endtask

   task automatic check_wb();
      check("wbWEN",      32'(wb_if.wbWEN),  32'(m_wen));
      check("wbwsel",     32'(wb_if.wbwsel), 32'(m_wsel));
      check("wbwdat",     wb_if.wbwdat,      m_wdat);
      check("wbinstr",    wb_if.wbinstr,     m_instr);
      check("wbHALT",     32'(wb_if.wbHALT), 32'(m_whalt));
      check("stallCount", 32'(stallCount),   32'(m_cnt));
   endtask

   // Pulls nRST low between edges, checks the async reset image, then releases.
   task automatic do_reset();
      nRST = 1'b0;
      #1;
      model_reset();
      check("rst_dREN",     32'(dREN),     32'd0);
      check("rst_dWEN",     32'(dWEN),     32'd0);
      check("rst_memStall", 32'(memStall), 32'd0);
      check_wb();
      #2;
      nRST = 1'b1;
   endtask

   // Called between edges with inputs already applied; checks combinational
   // outputs, advances the model across the next rising edge and checks the latch.
   task automatic do_cycle();
      logic        e_dre, e_dwe, e_stall;
      logic [31:0] e_wd;
      #1;
      e_dwe   = !m_halt && memcuDWE;
      e_dre   = !m_halt && memcuDRE && !memcuDWE;
      e_stall = (e_dre || e_dwe) && !dhit;
      check("dREN",     32'(dREN),     32'(e_dre));
      check("dWEN",     32'(dWEN),     32'(e_dwe));
      check("memStall", 32'(memStall), 32'(e_stall));
      check("daddr",    daddr,         memOutput_Port);
      check("dstore",   dstore,        memrdat2);
      prev_stall = e_stall;
      if (memMemToReg)     e_wd = dload;
      else if (memLUIflag) e_wd = {meminstr[15:0], 16'h0000};
      else                 e_wd = memOutput_Port;
      if (m_halt) begin
         m_wen = 1'b0;
      end else if (e_stall) begin
         m_wen = 1'b0;
         if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else if (wbFlush) begin
         m_wen = 1'b0; m_wsel = '0; m_wdat = '0; m_instr = '0;
      end else begin
         m_wen = memWEN; m_wsel = memwsel; m_wdat = e_wd; m_instr = meminstr;
         if (memcuHALT) begin
            m_halt  = 1'b1;
            m_whalt = 1'b1;
         end
      end
      @(posedge CLK);
      #1;
      check_wb();
   endtask

   task automatic set_op(input logic dre, input logic dwe, input logic halt, input logic m2r,
                         input logic lui, input logic wen, input logic [4:0] wsel,
                         input logic [31:0] outp, input logic [31:0] rd2, input logic [31:0] instr);
      memcuDRE = dre; memcuDWE = dwe; memcuHALT = halt; memMemToReg = m2r;
      memLUIflag = lui; memWEN = wen; memwsel = wsel;
      memOutput_Port = outp; memrdat2 = rd2; meminstr = instr;
      wbFlush = 1'b0; dhit = 1'b0; dload = '0;
   endtask

   task automatic rand_inputs();
      int kind;
      dload = $urandom;
      if (prev_stall) begin
         dhit    = ($urandom_range(0, 2) == 0);
         wbFlush = ($urandom_range(0, 3) == 0);
      end else begin
         kind = int'($urandom_range(0, 9));
         set_op(kind <= 2, kind == 3 || kind == 4, 1'b0, kind <= 2, kind == 5,
                1'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
         if (kind >= 6 && $urandom_range(0, 59) == 0) memcuHALT = 1'b1;
         dhit    = 1'($urandom);
         dload   = $urandom;
         wbFlush = ($urandom_range(0, 7) == 0);
      end
   endtask

   initial begin
      model_reset();
      #1;
      do_reset();

      // ALU result straight to write-back
      set_op(0, 0, 0, 0, 0, 1, 5'd5, 32'h10, 32'h0, 32'h0000_1111); do_cycle();
      // Load with three miss cycles then a hit
      set_op(1, 0, 0, 1, 0, 1, 5'd7, 32'h40, 32'h0, 32'h8C00_0040);
      repeat (3) do_cycle();
      dhit = 1'b1; dload = 32'hDEAD_BEEF; do_cycle();
      check("load_stalls", 32'(stallCount), 32'd3);
      // Store hitting in the same cycle
      set_op(0, 1, 0, 0, 0, 0, 5'd0, 32'h80, 32'h1234, 32'hAC00_0080);
      dhit = 1'b1; do_cycle();
      // LUI immediate
      set_op(0, 0, 0, 0, 1, 1, 5'd9, 32'h5555, 32'h0, 32'h3C09_ABCD); do_cycle();
      // Flush of a valid ALU op, then a flush that lands during a load stall
      set_op(0, 0, 0, 0, 0, 1, 5'd3, 32'h77, 32'h0, 32'h0000_0777);
      wbFlush = 1'b1; do_cycle();
      set_op(1, 0, 0, 1, 0, 1, 5'd4, 32'h44, 32'h0, 32'h8C04_0044);
      wbFlush = 1'b1; do_cycle();
      dhit = 1'b1; dload = 32'hCAFE_F00D; wbFlush = 1'b0; do_cycle();
      // Load pending, then HALT, then requests ignored while halted
      set_op(1, 0, 0, 1, 0, 1, 5'd6, 32'h60, 32'h0, 32'h8C06_0060);
      repeat (2) do_cycle();
      dhit = 1'b1; dload = 32'h0BAD_F00D; do_cycle();
      set_op(0, 0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF); do_cycle();
      set_op(1, 1, 0, 0, 0, 1, 5'd2, 32'h90, 32'h99, 32'h1234_5678); do_cycle();
      dhit = 1'b1; do_cycle();
      do_reset();
      // Reset abandoning a pending load
      set_op(1, 0, 0, 1, 0, 1, 5'd8, 32'h100, 32'h0, 32'h8C08_0100);
      repeat (2) do_cycle();
      do_reset();

      for (int i = 0; i < 1500; i++) begin
         if ((m_halt && $urandom_range(0, 15) == 0) || $urandom_range(0, 199) == 0)
            do_reset();
         rand_inputs();
         do_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
